// File: rtl/weight_loader_pkg.sv
// Shared types and default geometry for the weight FIFO reader that feeds
// the systolic PE-array weight chain.
package weight_loader_pkg;

    localparam int unsigned DEF_WEIGHT_BW   = 8;
    localparam int unsigned DEF_NUM_PE_ROWS = 8;
    localparam int unsigned DEF_MATRIX_SIZE = 8;

    localparam int unsigned ROW_W  = DEF_WEIGHT_BW * DEF_MATRIX_SIZE;
    localparam int unsigned TILE_W = ROW_W * DEF_NUM_PE_ROWS;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        CAPTURE,
        SHIFT,
        COMMIT
    } wl_state_e;

endpackage

// File: rtl/weight_loader_if.sv
// Weight FIFO read side plus PE-array row-beat channel; master is the loader,
// slave is the FIFO/array environment.
interface weight_loader_if
    import weight_loader_pkg::*;
#(
    parameter int unsigned WEIGHT_BW   = DEF_WEIGHT_BW,
    parameter int unsigned NUM_PE_ROWS = DEF_NUM_PE_ROWS,
    parameter int unsigned MATRIX_SIZE = DEF_MATRIX_SIZE
);
    localparam int unsigned ROW_BITS  = WEIGHT_BW * MATRIX_SIZE;
    localparam int unsigned TILE_BITS = ROW_BITS * NUM_PE_ROWS;
    localparam int unsigned IDX_W     = $clog2(NUM_PE_ROWS);

    logic                 fifo_empty;
    logic                 fifo_rd_en;
    logic [TILE_BITS-1:0] fifo_data;
    logic [ROW_BITS-1:0]  w_row_data;
    logic [IDX_W-1:0]     w_row_idx;
    logic                 w_row_valid;
    logic                 w_row_ready;
    logic                 w_commit;

    modport master (
        input  fifo_empty, fifo_data, w_row_ready,
        output fifo_rd_en, w_row_data, w_row_idx, w_row_valid, w_commit
    );

    modport slave (
        output fifo_empty, fifo_data, w_row_ready,
        input  fifo_rd_en, w_row_data, w_row_idx, w_row_valid, w_commit
    );

endinterface

// File: rtl/weight_loader.sv
// Pops one weight tile per load request, streams it into the PE array one
// row per accepted beat (highest row first) and then pulses a commit.
module weight_loader
    import weight_loader_pkg::*;
#(
    parameter int unsigned WEIGHT_BW   = DEF_WEIGHT_BW,
    parameter int unsigned NUM_PE_ROWS = DEF_NUM_PE_ROWS,
    parameter int unsigned MATRIX_SIZE = DEF_MATRIX_SIZE
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load_req,
    output logic            load_busy,
    output logic            load_done,
    weight_loader_if.master wl
);
    localparam int unsigned ROW_BITS  = WEIGHT_BW * MATRIX_SIZE;
    localparam int unsigned TILE_BITS = ROW_BITS * NUM_PE_ROWS;
    localparam int unsigned CNT_W     = $clog2(NUM_PE_ROWS);

    if (NUM_PE_ROWS < 2) begin : g_bad_rows
        $error("weight_loader: NUM_PE_ROWS must be at least 2");
    end

    wl_state_e            state;
    logic [TILE_BITS-1:0] tile_reg;
    logic [CNT_W-1:0]     row_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            tile_reg <= '0;
            row_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_req) state <= FETCH;
                end
                FETCH: begin
                    if (!wl.fifo_empty) state <= CAPTURE;
                end
                CAPTURE: begin
                    tile_reg <= wl.fifo_data;
                    row_cnt  <= CNT_W'(NUM_PE_ROWS - 1);
                    state    <= SHIFT;
                end
                SHIFT: begin
                    if (wl.w_row_ready) begin
                        if (row_cnt == '0) state <= COMMIT;
                        else               row_cnt <= row_cnt - 1'b1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Every strobe below is a pure decode of the state register; only the
    // pop strobe also looks at the FIFO flag so it never fires on empty.
    assign wl.fifo_rd_en  = (state == FETCH) && !wl.fifo_empty;
    assign wl.w_row_valid = (state == SHIFT);
    assign wl.w_commit    = (state == COMMIT);
    assign load_done      = (state == COMMIT);
    assign load_busy      = (state != IDLE);

    always_comb begin
        wl.w_row_data = '0;
        wl.w_row_idx  = '0;
        if (state == SHIFT) begin
            wl.w_row_data = tile_reg[row_cnt * ROW_BITS +: ROW_BITS];
            wl.w_row_idx  = row_cnt;
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Directed self-checking bench for weight_loader with a small FIFO model.
module tb_weight_loader;
    import weight_loader_pkg::*;

    localparam int unsigned WBW = 8;
    localparam int unsigned NR  = 8;
    localparam int unsigned MS  = 8;
    localparam int unsigned RB  = WBW * MS;
    localparam int unsigned TBW = RB * NR;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;
    logic load_req;
    logic load_busy;
    logic load_done;

    weight_loader_if #(.WEIGHT_BW(WBW), .NUM_PE_ROWS(NR), .MATRIX_SIZE(MS)) wl ();

    weight_loader #(.WEIGHT_BW(WBW), .NUM_PE_ROWS(NR), .MATRIX_SIZE(MS)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .load_req  (load_req),
        .load_busy (load_busy),
        .load_done (load_done),
        .wl        (wl)
    );

    // FIFO model: registered output, valid the cycle after the pop strobe.
    logic [TBW-1:0] tiles [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign wl.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (wl.fifo_rd_en && (wr_ptr != rd_ptr)) begin
            wl.fifo_data <= tiles[rd_ptr];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    int rd_cnt   = 0;
    int cm_cnt   = 0;
    int beat_cnt = 0;
    int bad_cnt  = 0;
    always @(posedge clk) begin
        if (rstn) begin
            if (wl.fifo_rd_en)                   rd_cnt   <= rd_cnt + 1;
            if (wl.w_commit)                     cm_cnt   <= cm_cnt + 1;
            if (wl.w_row_valid && wl.w_row_ready) beat_cnt <= beat_cnt + 1;
            if (wl.fifo_rd_en && wl.fifo_empty)  bad_cnt  <= bad_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    logic [63:0] last_row7;
    logic [63:0] last_row0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [TBW-1:0] make_tile(input logic [7:0] base);
        logic [TBW-1:0] t;
        t = '0;
        for (int k = 0; k < 64; k++) t[k*8 +: 8] = base + 8'(k);
        return t;
    endfunction

    function automatic logic [63:0] exp_row(input logic [7:0] base, input int r);
        logic [63:0] v;
        for (int b = 0; b < 8; b++) v[b*8 +: 8] = base + 8'(r*8 + b);
        return v;
    endfunction

    task automatic push(input logic [7:0] base);
        tiles[wr_ptr] = make_tile(base);
        wr_ptr = wr_ptr + 1;
    endtask

    // Entered in the FETCH cycle with a non-empty FIFO; ends in the COMMIT cycle.
    task automatic run_tile(input logic [7:0] base, input int pulse_row);
        check("fetch_rd_en", 64'(wl.fifo_rd_en), 64'd1);
        check("fetch_busy", 64'(load_busy), 64'd1);
        tick();
        check("cap_rd_en", 64'(wl.fifo_rd_en), 64'd0);
        check("cap_valid", 64'(wl.w_row_valid), 64'd0);
        for (int r = NR - 1; r >= 0; r--) begin
            tick();
            if (pulse_row >= 0) load_req = (r == pulse_row);
            check("row_valid", 64'(wl.w_row_valid), 64'd1);
            check("row_idx", 64'(wl.w_row_idx), 64'(r));
            check("row_data", wl.w_row_data, exp_row(base, r));
            check("shift_rd_en", 64'(wl.fifo_rd_en), 64'd0);
            if (r == NR - 1) last_row7 = wl.w_row_data;
            if (r == 0)      last_row0 = wl.w_row_data;
        end
        tick();
        if (pulse_row >= 0) load_req = 1'b0;
        check("commit", 64'(wl.w_commit), 64'd1);
        check("done", 64'(load_done), 64'd1);
        check("commit_valid", 64'(wl.w_row_valid), 64'd0);
        check("commit_data", wl.w_row_data, 64'd0);
        check("commit_busy", 64'(load_busy), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int c0;
        int b0;
        rstn           = 1'b0;
        load_req       = 1'b0;
        wl.w_row_ready = 1'b1;
        push(8'h00);
        #12;
        check("rst_busy", 64'(load_busy), 64'd0);
        check("rst_rd_en", 64'(wl.fifo_rd_en), 64'd0);
        check("rst_valid", 64'(wl.w_row_valid), 64'd0);
        check("rst_commit", 64'(wl.w_commit), 64'd0);
        check("rst_done", 64'(load_done), 64'd0);
        check("rst_data", wl.w_row_data, 64'd0);
        check("rst_idx", 64'(wl.w_row_idx), 64'd0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Single load, ready high
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        run_tile(8'h00, -1);
        check("t1_row7", last_row7, 64'h3F3E3D3C3B3A3938);
        check("t1_row0", last_row0, 64'h0706050403020100);
        tick();
        check("t1_idle_busy", 64'(load_busy), 64'd0);
        check("t1_idle_commit", 64'(wl.w_commit), 64'd0);

        // Empty FIFO stall
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall_busy", 64'(load_busy), 64'd1);
            check("stall_rd_en", 64'(wl.fifo_rd_en), 64'd0);
            check("stall_valid", 64'(wl.w_row_valid), 64'd0);
            tick();
        end
        push(8'h40);
        #1;
        run_tile(8'h40, -1);
        tick();
        check("stall_idle", 64'(load_busy), 64'd0);

        // Backpressure on row 5
        push(8'h80);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        check("bp_rd_en", 64'(wl.fifo_rd_en), 64'd1);
        tick();
        b0 = beat_cnt;
        for (int r = 7; r >= 6; r--) begin
            tick();
            check("bp_row", wl.w_row_data, exp_row(8'h80, r));
        end
        tick();
        wl.w_row_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            check("bp_hold_data", wl.w_row_data, exp_row(8'h80, 5));
            check("bp_hold_idx", 64'(wl.w_row_idx), 64'd5);
            check("bp_hold_valid", 64'(wl.w_row_valid), 64'd1);
        end
        wl.w_row_ready = 1'b1;
        for (int r = 4; r >= 0; r--) begin
            tick();
            check("bp_row", wl.w_row_data, exp_row(8'h80, r));
            check("bp_idx", 64'(wl.w_row_idx), 64'(r));
        end
        tick();
        check("bp_commit", 64'(wl.w_commit), 64'd1);
        check("bp_beats", 64'(beat_cnt - b0), 64'd8);
        tick();
        check("bp_idle", 64'(load_busy), 64'd0);

        // Back-to-back with load_req held high
        push(8'hA0);
        push(8'hC0);
        r0 = rd_cnt;
        c0 = cm_cnt;
        load_req = 1'b1;
        tick();
        run_tile(8'hA0, -1);
        tick();
        check("b2b_idle_gap", 64'(load_busy), 64'd0);
        tick();
        run_tile(8'hC0, -1);
        load_req = 1'b0;
        tick();
        check("b2b_idle1", 64'(load_busy), 64'd0);
        tick();
        check("b2b_idle2", 64'(load_busy), 64'd0);
        check("b2b_rd_pulses", 64'(rd_cnt - r0), 64'd2);
        check("b2b_commits", 64'(cm_cnt - c0), 64'd2);

        // Reset mid-SHIFT
        push(8'hE0);
        c0 = cm_cnt;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) tick();
        check("rs_pre_idx", 64'(wl.w_row_idx), 64'd4);
        rstn = 1'b0;
        #1;
        check("rs_busy", 64'(load_busy), 64'd0);
        check("rs_valid", 64'(wl.w_row_valid), 64'd0);
        check("rs_data", wl.w_row_data, 64'd0);
        check("rs_idx", 64'(wl.w_row_idx), 64'd0);
        check("rs_commit", 64'(wl.w_commit), 64'd0);
        check("rs_done", 64'(load_done), 64'd0);
        check("rs_rd_en", 64'(wl.fifo_rd_en), 64'd0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        check("rs_no_commit", 64'(cm_cnt - c0), 64'd0);
        check("rs_idle", 64'(load_busy), 64'd0);
        push(8'h10);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        run_tile(8'h10, -1);
        tick();
        check("rs_restart_idle", 64'(load_busy), 64'd0);
        check("rs_restart_commit", 64'(cm_cnt - c0), 64'd1);

        // Request during SHIFT is ignored
        push(8'h20);
        push(8'h30);
        r0 = rd_cnt;
        c0 = cm_cnt;
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        run_tile(8'h20, 5);
        tick();
        check("ign_idle1", 64'(load_busy), 64'd0);
        tick();
        check("ign_idle2", 64'(load_busy), 64'd0);
        check("ign_rd_pulses", 64'(rd_cnt - r0), 64'd1);
        check("ign_commits", 64'(cm_cnt - c0), 64'd1);

        check("rd_en_on_empty", 64'(bad_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
